// File: rtl/medfilt_pkg.sv
// Shared definitions for the 3x3 median filter engine: default sizes,
// the engine state encoding and the raster address helper.
package medfilt_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 12;
    localparam int IMG_W_DEF  = 13;
    localparam int IMG_H_DEF  = 13;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_MED     = 3'd3,
        S_EMIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Raster address of pixel (row, col) in an image img_w pixels wide.
    function automatic int unsigned pix_addr(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned img_w);
        return row * img_w + col;
    endfunction

endpackage

// File: rtl/median9.sv
// Combinational median of nine unsigned pixels using the classic
// 19 compare-exchange network; the median ends up in slot 4.
module median9
    import medfilt_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [9*DATA_W-1:0] i_pix,
    output logic [DATA_W-1:0]   o_med
);

    // Compare-exchange pairs, applied in order; after each step slot A <= slot B.
    localparam int CX_A [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
    localparam int CX_B [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

    logic [DATA_W-1:0] w_s [9];
    logic [DATA_W-1:0] w_t;

    // Unpack the window and run the exchange network.
    always_comb begin
        w_t = '0;
        for (int k = 0; k < 9; k++) begin
            w_s[k] = i_pix[k*DATA_W +: DATA_W];
        end
        for (int k = 0; k < 19; k++) begin
            if (w_s[CX_A[k]] > w_s[CX_B[k]]) begin
                w_t           = w_s[CX_A[k]];
                w_s[CX_A[k]]  = w_s[CX_B[k]];
                w_s[CX_B[k]]  = w_t;
            end
        end
    end

    assign o_med = w_s[4];

endmodule

// File: rtl/median3x3_engine.sv
// Reads the stored image back from pixel RAM and streams a 3x3
// median-filtered copy in raster order. Border pixels pass through.
//
// Output stream handshake: out_valid rises with out_addr/out_data already
// stable; they hold until the cycle in which out_valid && out_ready, which
// is the single transfer of that pixel. out_ready may be high early.
module median3x3_engine
    import medfilt_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        o_dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [3:0]        r_k;       // index of the read issued this cycle, 0..8
    logic [1:0]        r_wr;      // window row of that read (0 = row above)
    logic [1:0]        r_wc;      // window col of that read (0 = col left)
    logic              r_rd_d;    // a read was issued last cycle
    logic [3:0]        r_k_d;     // its window slot
    logic [DATA_W-1:0] r_win [9];
    logic              r_busy;
    logic              r_done;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;

    logic              w_interior;
    logic              w_last_pix;
    logic              w_hs;
    logic [ADDR_W-1:0] w_nrow;
    logic [ADDR_W-1:0] w_ncol;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_pix_addr;
    logic [9*DATA_W-1:0] w_win_flat;
    logic [DATA_W-1:0] w_med;

    assign w_interior = (r_row >= ONE) && (r_row < LAST_ROW) &&
                        (r_col >= ONE) && (r_col < LAST_COL);
    assign w_last_pix = (r_row == LAST_ROW) && (r_col == LAST_COL);
    assign w_hs       = (r_state == S_EMIT) && r_out_valid && out_ready;

    // Interior pixels walk the 3x3 neighbourhood; border pixels read only themselves.
    assign w_nrow     = w_interior ? (r_row + ADDR_W'(r_wr) - ONE) : r_row;
    assign w_ncol     = w_interior ? (r_col + ADDR_W'(r_wc) - ONE) : r_col;
    assign w_rd_addr  = ADDR_W'(pix_addr(32'(w_nrow), 32'(w_ncol), IMG_W));
    assign w_pix_addr = ADDR_W'(pix_addr(32'(r_row), 32'(r_col), IMG_W));

    assign rd_en       = (r_state == S_FETCH);
    assign rd_addr     = rd_en ? w_rd_addr : '0;
    assign busy        = r_busy;
    assign done        = r_done;
    assign out_valid   = r_out_valid;
    assign out_addr    = r_out_addr;
    assign out_data    = r_out_data;
    assign o_dbg_state = r_state;

    // Flatten the window registers for the median network.
    always_comb begin
        w_win_flat = '0;
        for (int k = 0; k < 9; k++) begin
            w_win_flat[k*DATA_W +: DATA_W] = r_win[k];
        end
    end

    median9 #(
        .DATA_W (DATA_W)
    ) u_median9 (
        .i_pix (w_win_flat),
        .o_med (w_med)
    );

    // RAM data returns one cycle after the strobe; park it in the slot of that read.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_rd_d <= 1'b0;
            r_k_d  <= '0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_rd_d <= rd_en;
            r_k_d  <= r_k;
            if (r_rd_d) begin
                r_win[r_k_d] <= rd_data;
            end
        end
    end

    // Run control: fetch, capture, optional median, emit, then advance in raster order.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_wr        <= '0;
            r_wc        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_k     <= '0;
                        r_wr    <= '0;
                        r_wc    <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (!w_interior || (r_k == 4'd8)) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_k <= r_k + 4'd1;
                        if (r_wc == 2'd2) begin
                            r_wc <= '0;
                            r_wr <= r_wr + 2'd1;
                        end else begin
                            r_wc <= r_wc + 2'd1;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (w_interior) begin
                        r_state <= S_MED;
                    end else begin
                        // Border: the datum landing in window[0] this cycle is the output.
                        r_state     <= S_EMIT;
                        r_out_valid <= 1'b1;
                        r_out_addr  <= w_pix_addr;
                        r_out_data  <= rd_data;
                    end
                end
                S_MED: begin
                    r_state     <= S_EMIT;
                    r_out_valid <= 1'b1;
                    r_out_addr  <= w_pix_addr;
                    r_out_data  <= w_med;
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        r_k         <= '0;
                        r_wr        <= '0;
                        r_wc        <= '0;
                        if (w_last_pix) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            if (r_col == LAST_COL) begin
                                r_col <= '0;
                                r_row <= r_row + ONE;
                            end else begin
                                r_col <= r_col + ONE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median3x3_engine.sv
// Bench for median3x3_engine: RAM model, reference median model feeding an
// expected queue, table of hand-computed windows, and stall/reset sequences.
module tb_median3x3_engine;
  import medfilt_pkg::*;

  localparam int W    = 13;
  localparam int H    = 13;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int NPIX = W * H;

  logic          clka = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [2:0]    dbg_state;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    gap;
  } exp_t;

  typedef struct packed {
    logic [71:0] win;
    logic [7:0]  exp_med;
    logic [3:0]  row;
    logic [3:0]  col;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        tbl [9];
  logic [7:0]  mem [NPIX];
  logic [7:0]  got [NPIX];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_hs = 0;
  int          hs_cnt = 0;
  bit          gap_check = 0;

  // ---------------- clock / reset ----------------
  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  median3x3_engine #(
    .IMG_W (W), .IMG_H (H), .ADDR_W (AW), .DATA_W (DW)
  ) dut (
    .clka        (clka),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .o_dbg_state (dbg_state)
  );

  // RAM model: data one cycle after the strobe
  always @(posedge clka) begin
    if (rd_en) rd_data <= (int'(rd_addr) < NPIX) ? mem[int'(rd_addr)] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_interior(int r, int c);
    return (r >= 1) && (r <= H - 2) && (c >= 1) && (c <= W - 2);
  endfunction

  function automatic logic [7:0] ref_pix(int r, int c);
    logic [7:0] v [9];
    logic [7:0] t;
    if (!is_interior(r, c)) return mem[r*W + c];
    for (int i = 0; i < 9; i++) v[i] = mem[(r - 1 + i/3)*W + (c - 1 + i%3)];
    for (int i = 1; i < 9; i++) begin
      for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
        t = v[j]; v[j] = v[j-1]; v[j-1] = t;
      end
    end
    return v[4];
  endfunction

  task automatic load_expected();
    exp_t e;
    exp_q.delete();
    hs_cnt = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.addr = AW'(r*W + c);
        e.data = ref_pix(r, c);
        e.gap  = is_interior(r, c) ? 4'd12 : 4'd3;
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clka) begin
    if (!reset && out_valid) begin
      check("rd_en_during_valid", rd_en, 0);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got addr 0x%0h data 0x%0h, required no output", out_addr, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_addr", out_addr, mon_e.addr);
          check("out_data", out_data, mon_e.data);
          if (gap_check) check("pixel_cycles", cyc - last_hs, mon_e.gap);
          if (int'(out_addr) < NPIX) got[int'(out_addr)] = out_data;
        end
        last_hs = cyc;
        hs_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run();
    @(posedge clka); #1;
    start = 1'b1;
    last_hs = cyc;
    @(posedge clka); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("first_rd_en", rd_en, 1);
    check("first_rd_addr", rd_addr, 0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 6000) begin
      @(posedge clka); #1;
      n++;
    end
    if (done !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: done=%0b, required 1", name, done);
    end else begin
      check({name, "_done_latency"}, cyc - last_hs, 1);
    end
    check({name, "_busy_low"}, busy, 0);
    check({name, "_out_count"}, hs_cnt, NPIX);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic run_stalled();
    int n;
    int hold;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    out_ready = 1'b0;
    gap_check = 0;
    load_expected();
    start_run();
    for (int p = 0; p < NPIX; p++) begin
      n = 0;
      while (!out_valid && n < 40) begin
        @(posedge clka); #1;
        n++;
      end
      if (!out_valid) begin
        n_cmp++; n_err++;
        $display("FAIL stall_wait_valid: out_valid=0 after 40 cycles, required 1 (pixel %0d)", p);
        break;
      end
      a = out_addr;
      d = out_data;
      hold = (p < 6) ? 5 : int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        @(posedge clka); #1;
        check("stall_valid", out_valid, 1);
        check("stall_addr", out_addr, a);
        check("stall_data", out_data, d);
        check("stall_rd_en", rd_en, 0);
      end
      out_ready = 1'b1;
      @(posedge clka); #1;
      out_ready = 1'b0;
      check("valid_drop_after_hs", out_valid, 0);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_rd_en"}, rd_en, 0);
    check({name, "_rd_addr"}, rd_addr, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_addr"}, out_addr, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_state"}, dbg_state, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = 8'h00;
      got[i] = 8'h00;
    end

    tbl[0] = '{72'h09_01_08_02_07_03_06_04_05, 8'h05, 4'd2, 4'd2};
    tbl[1] = '{72'hFF_FF_00_FF_00_FF_00_FF_00, 8'hFF, 4'd2, 4'd5};
    tbl[2] = '{72'h10_10_10_10_10_10_10_10_10, 8'h10, 4'd2, 4'd8};
    tbl[3] = '{72'h01_02_03_04_05_06_07_08_09, 8'h05, 4'd5, 4'd2};
    tbl[4] = '{72'hFF_FE_00_01_80_7F_81_02_FD, 8'h80, 4'd5, 4'd5};
    tbl[5] = '{72'h03_03_03_01_01_01_02_02_02, 8'h02, 4'd5, 4'd8};
    tbl[6] = '{72'h00_00_00_00_00_FF_FF_FF_FF, 8'h00, 4'd8, 4'd2};
    tbl[7] = '{72'hC8_32_64_96_FA_0A_46_B4_1E, 8'h64, 4'd8, 4'd5};
    tbl[8] = '{72'h07_07_09_09_08_08_08_01_FF, 8'h08, 4'd8, 4'd8};

    repeat (3) @(posedge clka);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // Run 1: constant image, ready always high, start pulse while busy ignored
    for (int i = 0; i < NPIX; i++) mem[i] = 8'h40;
    out_ready = 1'b1;
    gap_check = 1;
    load_expected();
    start_run();
    repeat (30) @(posedge clka);
    #1;
    start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    check("busy_ignore_start", busy, 1);
    wait_done("const");
    check("const_corner_pixel", got[NPIX-1], 8'h40);

    // Run 2: impulse image under backpressure
    for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
    mem[5*W + 5] = 8'hFF;
    run_stalled();
    wait_done("impulse");
    check("impulse_removed", got[5*W + 5], 8'h00);

    // Run 3: ramp image, fresh start straight from DONE
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i & 8'hFF);
    out_ready = 1'b1;
    gap_check = 1;
    load_expected();
    start_run();
    wait_done("ramp");
    check("ramp_border", got[12], 8'd12);
    check("ramp_interior", got[1*W + 1], 8'd14);
    check("ramp_interior_last", got[11*W + 11], 8'd154);

    // Run 4: table of hand-computed windows at non-overlapping interior pixels
    for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 9; k++) begin
        mem[(int'(tbl[i].row) - 1 + k/3)*W + int'(tbl[i].col) - 1 + k%3] = tbl[i].win[(8-k)*8 +: 8];
      end
    end
    load_expected();
    start_run();
    wait_done("table");
    for (int i = 0; i < 9; i++) begin
      check($sformatf("table_%0d", i), got[int'(tbl[i].row)*W + int'(tbl[i].col)], tbl[i].exp_med);
    end

    // Reset in the middle of a fetch
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i & 8'hFF);
    load_expected();
    start_run();
    repeat (25) @(posedge clka);
    #1;
    n = 0;
    while (!rd_en && n < 20) begin
      @(posedge clka); #1;
      n++;
    end
    check("rd_en_before_reset", rd_en, 1);
    reset = 1'b1;
    @(posedge clka); #1;
    check_idle_outputs("mid_reset");
    exp_q.delete();
    @(posedge clka); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clka); #1;
      check("post_reset_rd_en", rd_en, 0);
      check("post_reset_valid", out_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/median3x3_engine.md
# median3x3_engine

Downstream stage of the pixel-RAM loader: once the loader has filled the 8-bit image RAM, this block reads the stored image back through the RAM port and produces a 3x3 median-filtered image. Pixels come out in raster order on a valid/ready stream. Interior pixels take the median of their 3x3 neighbourhood; border pixels pass through unchanged. The RAM-port mux between loader and engine lives outside this block, selected by `busy`.

## Interface
- IMG_W, 13: image width in pixels (≥3)
- IMG_H, 13: image height in pixels (≥3)
- ADDR_W, 12: RAM address width; IMG_W*IMG_H ≤ 2^ADDR_W
- DATA_W, 8: pixel width
- clka  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a run from IDLE/DONE, ignored otherwise
- busy  out  1  high from the cycle after an accepted start until the run finishes
- done  out  1  level; high after the last pixel handshake, cleared by the next accepted start
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address, row*IMG_W+col
- rd_data  in  DATA_W  RAM read data, valid exactly one cycle after rd_en
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accept
- out_addr  out  ADDR_W  raster address of output pixel
- out_data  out  DATA_W  filtered pixel

## Operation
- Reset value of every output is 0. State goes to IDLE and row/col counters are cleared. Reset mid-run aborts the run immediately; no further rd_en or out_valid.
- States: IDLE, FETCH, CAPTURE, MED, EMIT, DONE.
- IDLE/DONE + start → FETCH at (row 0, col 0), with busy=1 and done=0.
- FETCH: one read per cycle, rd_en=1.
  - Interior pixel (1≤row≤IMG_H-2, 1≤col≤IMG_W-2): 9 reads in the order (r-1,c-1),(r-1,c),(r-1,c+1),(r,c-1)…(r+1,c+1).
  - Border pixel: 1 read at (r,c).
- Window register k captures rd_data on the cycle after read k.
- After the last read → CAPTURE: rd_en=0, last datum captured.
- CAPTURE → MED for an interior pixel, or → EMIT for a border pixel.
- MED: registers the output of the median9 sub-module into out_data. Next state is EMIT.
- Border path: EMIT loads out_data from window[0].
- EMIT: out_valid=1, and out_addr/out_data stay stable until out_valid&&out_ready.
- On handshake:
  - If not the last pixel, advance col (wrap to 0 and increment row at IMG_W-1), then → FETCH.
  - Last pixel (IMG_H-1, IMG_W-1): → DONE, with busy=0 and done=1 in the following cycle.
- start while busy is ignored.
- Median is unsigned comparison over DATA_W bits. Duplicate values are legal; the result is the 5th smallest.

## Timing
- Pixel start = cycle 0 (first FETCH cycle).
- Interior pixel: reads in cycles 0–8, CAPTURE in cycle 9, MED in cycle 10, out_valid from cycle 11.
- Border pixel: read in cycle 0, CAPTURE in cycle 1, out_valid from cycle 2.
- With out_ready held high, the next pixel's FETCH starts the cycle after the handshake. Interior pixel = 12 cycles, border pixel = 3 cycles.
- start accepted at cycle t → first rd_en at cycle t+1.
- rd_en is never high while out_valid is high.
- Zero-cycle backpressure: out_ready may be high before out_valid.

## Structure
- Shared package `medfilt_pkg` holds:
  - DATA_W/ADDR_W defaults and IMG_W/IMG_H defaults
  - the state enum (IDLE…DONE)
  - a function computing row*IMG_W+col
- Sub-module `median9` is purely combinational. It takes 9 DATA_W inputs and produces their median via a 19-compare-exchange network.
- The engine owns the FSM, counters, window registers and output registers.

## Test plan
- Constant image, all 0x40; IMG_W=IMG_H=13; out_ready=1 → 169 outputs, all 0x40, addresses 0..168 in order; done high after the last handshake.
- Zero image with a single 0xFF at (5,5) → every output is 0x00, impulse removed.
- Image where pixel = (row*IMG_W+col)&0xFF → border outputs equal their input; interior (r,c) outputs the value at (r,c); timing is 3 cycles per border pixel and 12 per interior pixel.
- Window containing 9,1,8,2,7,3,6,4,5 at an interior pixel → out_data=5. All 0xFF except four 0x00 → 0xFF.
- out_ready held low for 5 cycles during an EMIT → out_valid, out_addr and out_data stay constant; rd_en stays 0; the pixel is accepted once on release.
- reset asserted mid-FETCH → all outputs 0 next cycle. start pulsed while busy → ignored. A fresh start after DONE clears done and reruns from address 0.
